// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit for the execute stage.
// Runs MULT/MULTU (and DIV/DIVU when MDU_DIV_EN is defined) over WIDTH+1
// busy cycles (WIDTH RUN cycles plus one FIX cycle), then holds the result
// in HI/LO. It also services MTHI/MTLO writes while idle.
//
// Configuration macro: MDU_DIV_EN -- builds the divider datapath. Without
// it, starts with opE[1]=1 are not accepted and div0 is tied low.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   startE, opE       mult/div request; op 00 MULT 01 MULTU 10 DIV 11 DIVU
//   srcaE, srcbE      rs / rt operands
//   hi_weE, lo_weE    MTHI / MTLO write enables, data on wdataE
//   hi, lo            HI / LO registers
//   stallE            combinational stall request to the hazard unit
//   busy              registered, high while not IDLE
//   done              one-cycle pulse during the FIX cycle
//   div0              sticky: last division had a zero divisor
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             hi_weE,
  input  logic             lo_weE,
  input  logic [WIDTH-1:0] wdataE,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stallE,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting out / quotient in}.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;     // multiplicand magnitude or divisor magnitude
  logic               neg_q;    // product / quotient sign

  logic               op_ok;
  logic               accept;
  logic               sgn, sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc_init;
  logic [WIDTH-1:0]   opnd_init;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] step_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

`ifdef MDU_DIV_EN
  logic               is_div_q;
  logic               rem_neg_q;
  logic               b_zero_q;
  logic [WIDTH-1:0]   a_q;      // original dividend, returned in HI on /0
  logic [WIDTH:0]     part, diff;
  logic [WIDTH-1:0]   rem_new;

  assign op_ok = 1'b1;
`else
  assign op_ok = ~opE[1];
  assign div0  = 1'b0;
`endif

  assign accept = startE & op_ok & (state == IDLE);
  assign stallE = accept | (state == RUN);

  // Operand preparation: signed ops work on magnitudes.
  always_comb begin
    sgn       = ~opE[0];
    sa        = sgn & srcaE[WIDTH-1];
    sb        = sgn & srcbE[WIDTH-1];
    mag_a     = sa ? ('0 - srcaE) : srcaE;
    mag_b     = sb ? ('0 - srcbE) : srcbE;
    acc_init  = {{WIDTH{1'b0}}, mag_b};
    opnd_init = mag_a;
`ifdef MDU_DIV_EN
    if (opE[1]) begin
      acc_init  = {{WIDTH{1'b0}}, mag_a};
      opnd_init = mag_b;
    end
`endif
  end

  // One iteration step.
  always_comb begin
    sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    step_next = {sum, acc[WIDTH-1:1]};
`ifdef MDU_DIV_EN
    // Restoring step: shift in next dividend bit, subtract divisor if it fits.
    part    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = part - {1'b0, opnd};
    rem_new = diff[WIDTH] ? part[WIDTH-1:0] : diff[WIDTH-1:0];
    if (is_div_q) begin
      step_next = {rem_new, acc[WIDTH-2:0], ~diff[WIDTH]};
    end
`endif
  end

  // Sign correction for the FIX commit.
  always_comb begin
    prod   = neg_q ? ('0 - acc) : acc;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
    if (is_div_q) begin
      if (b_zero_q) begin
        res_hi = a_q;
        res_lo = '1;
      end else begin
        res_lo = neg_q ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        res_hi = rem_neg_q ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      neg_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hi        <= '0;
      lo        <= '0;
`ifdef MDU_DIV_EN
      is_div_q  <= 1'b0;
      rem_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
      a_q       <= '0;
      div0      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_weE) hi <= wdataE;
          if (lo_weE) lo <= wdataE;
          if (accept) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
            acc   <= acc_init;
            opnd  <= opnd_init;
            neg_q <= sa ^ sb;
`ifdef MDU_DIV_EN
            is_div_q  <= opE[1];
            rem_neg_q <= sa;
            b_zero_q  <= (srcbE == '0);
            a_q       <= srcaE;
            div0      <= 1'b0;
`endif
          end
        end
        RUN: begin
          acc <= step_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= FIX;
            cnt   <= '0;
            done  <= 1'b1;
          end
        end
        FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          state <= IDLE;
          busy  <= 1'b0;
`ifdef MDU_DIV_EN
          div0  <= is_div_q & b_zero_q;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the pipelined MIPS core, attached to the execute stage beside the ALU. It performs MULT/MULTU/DIV/DIVU on WIDTH-bit operands over WIDTH+1 busy cycles, then holds the 2·WIDTH-bit result in HI/LO registers. While it is busy it raises a stall request to the hazard unit. It also services MTHI/MTLO writes and supplies HI/LO to the execute-stage result path for MFHI/MFLO.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; minimum 4.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, synchronous, active-high
- startE  in  1  execute-stage instruction is a mult/div op
- opE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- srcaE  in  WIDTH  forwarded rs value (multiplicand / dividend)
- srcbE  in  WIDTH  forwarded rt value (multiplier / divisor)
- hi_weE  in  1  MTHI write enable
- lo_weE  in  1  MTLO write enable
- wdataE  in  WIDTH  MTHI/MTLO data (forwarded rs)
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- stallE  out  1  stall request to the hazard unit (combinational)
- busy  out  1  operation in progress (registered)
- done  out  1  one-cycle pulse in the FIX cycle
- div0  out  1  sticky flag: the last division had divisor 0

## Operation
- States:
  - IDLE: default state.
  - RUN: counter runs 0..WIDTH-1.
  - FIX: sign correction and result commit.
- Start acceptance: startE is accepted only in IDLE. It latches the operands and opE and moves to RUN with counter=0. startE in RUN or FIX is ignored.
- Operand preparation:
  - Signed ops (MULT, DIV): the unit works on operand magnitudes and records result signs.
  - Product sign = sa^sb.
  - Quotient sign = sa^sb; remainder sign = sa.
- RUN, multiply: shift-add, one multiplier bit per cycle, LSB first, into a 2·WIDTH accumulator.
- RUN, divide: restoring division, one quotient bit per cycle, MSB first.
- RUN exit: RUN lasts exactly WIDTH cycles, then goes to FIX.
- FIX: negates the product, quotient and remainder as their signs require. Writes the result: multiply gives HI=upper and LO=lower; divide gives LO=quotient and HI=remainder. Asserts done, then returns to IDLE.
- Divide by zero: LO = all ones, HI = dividend. div0 is set in FIX and cleared by the next accepted start.
- Signed overflow:
  - Most-negative / -1 gives LO=most-negative, HI=0 (two's-complement wrap).
  - Most-negative × most-negative is exact in 2·WIDTH bits.
- MTHI/MTLO: hi_weE/lo_weE write wdataE at the clock edge, only in IDLE. In RUN/FIX the writes are ignored.
- Start with a simultaneous write in IDLE: the write lands, then FIX overwrites it.
- stallE = (startE & IDLE) | RUN. It is low in FIX, so the stalled instruction leaves execute during FIX and its still-high startE is ignored.
- busy = (state != IDLE).

## Timing
- Start sampled at the end of cycle 0.
- RUN occupies cycles 1..WIDTH; FIX is cycle WIDTH+1.
- New HI/LO is visible from cycle WIDTH+2. Total latency is WIDTH+2 cycles.
- stallE is high in cycles 0..WIDTH.
- done is high in cycle WIDTH+1 only.
- An instruction decoded right after the mult reaches execute in cycle WIDTH+2 and reads the updated HI/LO. No extra forwarding is needed.
- Back-to-back ops: a second startE in cycle WIDTH+2 (state IDLE) is accepted.
- Reset (any state, including mid-RUN): at the next edge state=IDLE, hi=lo=0, busy=0, done=0, div0=0, counter=0. stallE=0 after reset unless startE is high.

## Configuration
- MDU_DIV_EN defined: divider datapath and DIV/DIVU supported as above.
- MDU_DIV_EN undefined: only MULT/MULTU are built.
  - startE with opE[1]=1 is not accepted: no stall, HI/LO unchanged, done not pulsed.
  - div0 is tied to 0.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF, WIDTH=32 -> HI=0xFFFFFFFE, LO=0x00000001 in cycle 34; stallE high cycles 0..32; done high in cycle 33 only.
- MULT -3 × 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0x00000000.
- DIV -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU 5 / 0 -> LO=0xFFFFFFFF, HI=5, div0=1; a following MULTU clears div0.
- startE held high through the stall, then a second MULTU 2×3 presented in cycle 34 -> the first op is not restarted; the second is accepted; HI=0, LO=6 in cycle 68.
- MTLO 0x1234 in IDLE -> LO=0x1234 next cycle; MTHI 0x55 during RUN -> HI unaffected by the write.
- rst asserted in cycle 10 of a DIV -> cycle 11: hi=lo=0, busy=0, stallE=0 (startE low), no done pulse.
